div_seq: RTL and testbench

- Parametrised multi-cycle integer divider; next generation of the single-cycle divide unit.
- Restoring shift-subtract, one quotient bit per clock; signed or unsigned per operation; start/done handshake.
- Sits beside the multiplier in the execute stage and writes the LO/HI pair.
- Flags divide-by-zero on the exception output for the control unit.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 34 +++
 rtl/div_seq.sv | 139 +++++++++++++
 tb/tb_div_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider (div_seq).
// Holds the FSM state type, the default operand width and sizing helpers.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Cycles from the start sample to the done cycle for a normal operation.
    function automatic int latency(input int width);
        return width + 2;
    endfunction

    // Bits needed by the iteration counter.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration, purely combinational.
// Shifts {rem,quot} left by one, trial-subtracts the divisor from the
// partial remainder and keeps the difference when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic [WIDTH-1:0] next_quot
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;

    // Trial subtraction; the top bit of diff acts as the borrow.
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        diff    = shifted - {2'b00, divisor};
        fits    = ~diff[WIDTH+1];
        if (fits) begin
            next_rem  = diff[WIDTH:0];
            next_quot = {quot[WIDTH-2:0], 1'b1};
        end else begin
            next_rem  = shifted[WIDTH:0];
            next_quot = {quot[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Signed or unsigned per operation; start/done handshake; lo = quotient,
// hi = remainder, exception = divide-by-zero for the last completed op.
// Build option: DIV_ZERO_FAST_EN completes a zero-divisor request in one
// cycle without entering RUN; otherwise it takes the full latency.
//
// Handshake: start is sampled only in IDLE; the operands and is_signed are
// captured on that edge. done is a one-cycle pulse in the cycle where
// lo/hi/exception carry the new result; start may be high in that cycle.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] Data_a,
    input  logic [WIDTH-1:0] Data_b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic             exception
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             fast_zero;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quot;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = (Data_b == '0);
`else
    assign fast_zero = 1'b0;
`endif

    // Operand magnitudes; only signed negative operands are negated.
    always_comb begin
        mag_a = (is_signed && Data_a[WIDTH-1]) ? -Data_a : Data_a;
        mag_b = (is_signed && Data_b[WIDTH-1]) ? -Data_b : Data_b;
    end

    // Sign correction of the unsigned result applied in FIX.
    always_comb begin
        q_fix = neg_q ? -quot : quot;
        r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (divisor),
        .next_rem  (step_rem),
        .next_quot (step_quot)
    );

    // Control FSM with registered outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            rem       <= '0;
            quot      <= '0;
            divisor   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_div  <= 1'b0;
            lo        <= '0;
            hi        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            exception <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && fast_zero) begin
                        // Zero divisor resolved immediately; lo/hi untouched.
                        done      <= 1'b1;
                        exception <= 1'b1;
                    end else if (start) begin
                        rem       <= '0;
                        quot      <= mag_a;
                        divisor   <= mag_b;
                        neg_q     <= is_signed & (Data_a[WIDTH-1] ^ Data_b[WIDTH-1]);
                        neg_r     <= is_signed & Data_a[WIDTH-1];
                        zero_div  <= (Data_b == '0);
                        count     <= '0;
                        exception <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    rem   <= step_rem;
                    quot  <= step_quot;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (!zero_div) begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end
                    exception <= zero_div;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq at WIDTH=32: latency, busy span, signed and
// unsigned results, divide-by-zero, ignored restart and mid-op reset.
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        busy;
    logic        done;
    logic        exception;

    int n_checks;
    int n_fail;
    int cycles;
    int busy_cycles;
    int exp_zero_cycles;
    int exp_zero_busy;
    logic done_seen;

    div_seq #(
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .Data_a    (data_a),
        .Data_b    (data_b),
        .lo        (lo),
        .hi        (hi),
        .busy      (busy),
        .done      (done),
        .exception (exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives start for one cycle from the current time (just after an edge)
    // and waits, bounded, for done. Counts edges to done and busy cycles.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int n_cyc, output int n_busy);
        start     = 1'b1;
        data_a    = a;
        data_b    = b;
        is_signed = sgn;
        n_cyc     = 0;
        n_busy    = 0;
        done_seen = 1'b0;
        while (!done_seen && n_cyc < 100) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n_cyc++;
            if (busy) n_busy++;
            if (done) done_seen = 1'b1;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        data_a    = '0;
        data_b    = '0;
`ifdef DIV_ZERO_FAST_EN
        exp_zero_cycles = 1;
        exp_zero_busy   = 0;
`else
        exp_zero_cycles = 34;
        exp_zero_busy   = 33;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_lo", lo, 32'h0);
        check("reset_hi", hi, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_exc", {31'b0, exception}, 32'h0);

        // Unsigned 100 / 7
        @(posedge clk);
        #1;
        do_op(32'd100, 32'd7, 1'b0, cycles, busy_cycles);
        check("u100_7_latency", cycles, 32'd34);
        check("u100_7_busy_cycles", busy_cycles, 32'd33);
        check("u100_7_lo", lo, 32'd14);
        check("u100_7_hi", hi, 32'd2);
        check("u100_7_exc", {31'b0, exception}, 32'h0);
        check("u100_7_busy_at_done", {31'b0, busy}, 32'h0);

        // Done is a single-cycle pulse
        @(posedge clk);
        #1;
        check("done_pulse_width", {31'b0, done}, 32'h0);

        // Divide by zero holds lo/hi
        do_op(32'd5, 32'd0, 1'b0, cycles, busy_cycles);
        check("div0_latency", cycles, exp_zero_cycles);
        check("div0_busy_cycles", busy_cycles, exp_zero_busy);
        check("div0_exc", {31'b0, exception}, 32'h1);
        check("div0_lo_held", lo, 32'd14);
        check("div0_hi_held", hi, 32'd2);

        // Back-to-back: start in the done cycle; also clears exception
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, cycles, busy_cycles);
        check("s_m7_2_latency", cycles, 32'd34);
        check("s_m7_2_lo", lo, 32'hFFFF_FFFD);
        check("s_m7_2_hi", hi, 32'hFFFF_FFFF);
        check("s_m7_2_exc", {31'b0, exception}, 32'h0);

        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, cycles, busy_cycles);
        check("s_7_m2_lo", lo, 32'hFFFF_FFFD);
        check("s_7_m2_hi", hi, 32'h0000_0001);

        do_op(32'd100, 32'hFFFF_FFF9, 1'b1, cycles, busy_cycles);
        check("s_100_m7_lo", lo, 32'hFFFF_FFF2);
        check("s_100_m7_hi", hi, 32'd2);

        do_op(32'hFFFF_FF9C, 32'd7, 1'b1, cycles, busy_cycles);
        check("s_m100_7_lo", lo, 32'hFFFF_FFF2);
        check("s_m100_7_hi", hi, 32'hFFFF_FFFE);

        // Signed overflow wraps
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cycles, busy_cycles);
        check("s_ovf_lo", lo, 32'h8000_0000);
        check("s_ovf_hi", hi, 32'h0);
        check("s_ovf_exc", {31'b0, exception}, 32'h0);

        // Same operands unsigned
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cycles, busy_cycles);
        check("u_big_lo", lo, 32'h0);
        check("u_big_hi", hi, 32'h8000_0000);

        // Results hold between completions
        repeat (4) @(posedge clk);
        #1;
        check("hold_lo", lo, 32'h0);
        check("hold_hi", hi, 32'h8000_0000);

        // Start while busy is ignored
        start     = 1'b1;
        data_a    = 32'hFFFF_FFFF;
        data_b    = 32'd3;
        is_signed = 1'b0;
        cycles    = 0;
        done_seen = 1'b0;
        while (!done_seen && cycles < 100) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
            if (cycles == 5) begin
                start     = 1'b1;
                data_a    = 32'd10;
                data_b    = 32'd2;
                is_signed = 1'b1;
            end
            if (done) done_seen = 1'b1;
        end
        check("ignore_latency", cycles, 32'd34);
        check("ignore_lo", lo, 32'h5555_5555);
        check("ignore_hi", hi, 32'h0);

        // Reset in the middle of an operation
        @(posedge clk);
        #1;
        start     = 1'b1;
        data_a    = 32'hFFFF_FFFF;
        data_b    = 32'd3;
        is_signed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("midop_busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_lo", lo, 32'h0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_done", {31'b0, done}, 32'h0);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen = 1'b1;
        end
        check("midrst_no_done", {31'b0, done_seen}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
